// File: rtl/bp_me_best_offset_learner_if.sv
// bp_me_best_offset_learner_if: miss/fill request bus and offset result bus of the best-offset learner.
//   miss_v/miss_addr/miss_ready_and : demand-miss handshake (byte address)
//   fill_v/fill_addr                : completed fill (byte address, no backpressure)
//   offset_v/offset/learn_done      : learned signed line offset, enable, phase-end pulse
interface bp_me_best_offset_learner_if #(
  parameter int addr_width_p = 40,
  parameter int lg_offsets_p = 4
);
  logic                    miss_v;
  logic                    miss_ready_and;
  logic [addr_width_p-1:0] miss_addr;
  logic                    fill_v;
  logic [addr_width_p-1:0] fill_addr;
  logic                    offset_v;
  logic [lg_offsets_p+1:0] offset;
  logic                    learn_done;
  modport master (
    output miss_v, miss_addr, fill_v, fill_addr,
    input  miss_ready_and, offset_v, offset, learn_done
  );
  modport slave (
    input  miss_v, miss_addr, fill_v, fill_addr,
    output miss_ready_and, offset_v, offset, learn_done
  );
endinterface

// File: rtl/bp_me_best_offset_learner.sv
// bp_me_best_offset_learner: best-offset prefetch learner scoring candidate line offsets against a recent-requests table.
//   clk_i      : clock
//   reset_n_i  : asynchronous reset, active low
//   bus        : bp_me_best_offset_learner_if.slave (miss handshake, fill, offset result)
//   Build option BP_ME_BOP_NEGATIVE_OFFSETS_EN: 2N candidates alternating +k / -k.
module bp_me_best_offset_learner #(
  parameter int addr_width_p         = 40,
  parameter int block_offset_width_p = 6,
  parameter int lg_offsets_p         = 4,
  parameter int lg_rr_els_p          = 4,
  parameter int rr_tag_width_p       = 12,
  parameter int max_score_p          = 31,
  parameter int bad_score_p          = 1,
  parameter int max_rounds_p         = 100
) (
  input logic clk_i,
  input logic reset_n_i,
  bp_me_best_offset_learner_if.slave bus
);
  localparam int line_w  = addr_width_p - block_offset_width_p;
  localparam int off_w   = lg_offsets_p + 2;
  localparam int ext_w   = line_w - off_w;
  localparam int score_w = $clog2(max_score_p + 1);
  localparam int round_w = $clog2(max_rounds_p + 1);
  localparam int rr_els  = 2 ** lg_rr_els_p;
`ifdef BP_ME_BOP_NEGATIVE_OFFSETS_EN
  localparam int idx_w = lg_offsets_p + 1;
`else
  localparam int idx_w = lg_offsets_p;
`endif
  localparam int n_cand = 2 ** idx_w;

  typedef enum logic {e_learn, e_end} state_e;
  state_e state_r, state_n;

  logic [idx_w-1:0]          idx_r;
  logic [round_w-1:0]        round_r;
  logic [score_w-1:0]        score_r [n_cand];
  logic [score_w-1:0]        best_score_r, score_inc;
  logic [off_w-1:0]          best_r, offset_r, cand;
  logic                      offset_v_r;
  logic [rr_els-1:0]         rr_v_r;
  logic [rr_tag_width_p-1:0] rr_tag_r [rr_els];
  logic [line_w-1:0]         miss_line, fill_line, test, base;
  logic                      hs, hit, end_phase, unused;

  // Candidate index walks the list in order; its natural overflow is the round wrap.
`ifdef BP_ME_BOP_NEGATIVE_OFFSETS_EN
  logic [off_w-1:0] mag;
  assign mag  = off_w'(idx_r >> 1) + off_w'(1);
  assign cand = idx_r[0] ? -mag : mag;
`else
  assign cand = off_w'(idx_r) + off_w'(1);
`endif

  assign miss_line = bus.miss_addr[addr_width_p-1:block_offset_width_p];
  assign fill_line = bus.fill_addr[addr_width_p-1:block_offset_width_p];
  assign test      = miss_line - {{ext_w{cand[off_w-1]}}, cand};
  // Fills are stored as the line that would have triggered them under the current offset.
  assign base      = fill_line - (offset_v_r ? {{ext_w{offset_r[off_w-1]}}, offset_r} : '0);
  assign hs        = bus.miss_v & (state_r == e_learn);
  assign hit       = hs & rr_v_r[test[lg_rr_els_p-1:0]]
                   & (rr_tag_r[test[lg_rr_els_p-1:0]] == test[lg_rr_els_p +: rr_tag_width_p]);
  assign score_inc = score_r[idx_r] + score_w'(1);
  assign end_phase = (hit & (score_inc == score_w'(max_score_p)))
                   | (hs & (&idx_r) & (round_r + round_w'(1) == round_w'(max_rounds_p)));
  assign unused    = ^{bus.miss_addr[block_offset_width_p-1:0], bus.fill_addr[block_offset_width_p-1:0],
                       test[line_w-1:lg_rr_els_p+rr_tag_width_p], base[line_w-1:lg_rr_els_p+rr_tag_width_p]};

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_r <= e_learn;
    else            state_r <= state_n;

  always_comb begin
    state_n            = (state_r == e_end) ? e_learn : (end_phase ? e_end : e_learn);
    bus.miss_ready_and = (state_r == e_learn);
    bus.learn_done     = (state_r == e_end);
  end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      idx_r        <= '0;
      round_r      <= '0;
      best_score_r <= '0;
      best_r       <= '0;
      offset_r     <= off_w'(1);
      offset_v_r   <= 1'b1;
      rr_v_r       <= '0;
      for (int i = 0; i < n_cand; i++) score_r[i] <= '0;
    end else begin
      if (bus.fill_v) rr_v_r[base[lg_rr_els_p-1:0]] <= 1'b1;
      if (state_r == e_end) begin
        if (best_score_r > score_w'(bad_score_p)) begin
          offset_r   <= best_r;
          offset_v_r <= 1'b1;
        end else
          offset_v_r <= 1'b0;
        idx_r        <= '0;
        round_r      <= '0;
        best_score_r <= '0;
        best_r       <= '0;
        for (int i = 0; i < n_cand; i++) score_r[i] <= '0;
      end else if (hs) begin
        idx_r <= idx_r + idx_w'(1);
        if (&idx_r) round_r <= round_r + round_w'(1);
        if (hit) begin
          score_r[idx_r] <= score_inc;
          if (score_inc > best_score_r) begin
            best_score_r <= score_inc;
            best_r       <= cand;
          end
        end
      end
    end

  // Tags need no reset: a stale tag is masked by its cleared valid bit.
  always_ff @(posedge clk_i)
    if (bus.fill_v) rr_tag_r[base[lg_rr_els_p-1:0]] <= base[lg_rr_els_p +: rr_tag_width_p];

  assign bus.offset_v = offset_v_r;
  assign bus.offset   = offset_r;
endmodule

// File: tb/tb_bp_me_best_offset_learner.sv
// tb_bp_me_best_offset_learner: directed self-checking bench for the best-offset learner (small config).
module tb_bp_me_best_offset_learner;
  typedef logic [33:0] line_t;
`ifdef BP_ME_BOP_NEGATIVE_OFFSETS_EN
  localparam int nc = 8;
`else
  localparam int nc = 4;
`endif
  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  int checks = 0;
  int errors = 0;
  int at;
  logic d;
  line_t pat [8];

  always #5 clk_i = ~clk_i;

  bp_me_best_offset_learner_if #(.addr_width_p(40), .lg_offsets_p(2)) bus();

  bp_me_best_offset_learner #(
    .addr_width_p(40), .block_offset_width_p(6), .lg_offsets_p(2), .lg_rr_els_p(4),
    .rr_tag_width_p(12), .max_score_p(3), .bad_score_p(1), .max_rounds_p(4)
  ) dut (.clk_i(clk_i), .reset_n_i(reset_n_i), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic op(input line_t ml, input logic mv, input logic fv, input line_t fl, output logic done);
    int k = 0;
    @(negedge clk_i);
    while (mv && !bus.miss_ready_and && k < 4) begin
      @(negedge clk_i);
      k++;
    end
    if (k == 4) chk("ready_timeout", 0, 1);
    bus.miss_v    = mv;
    bus.miss_addr = {ml, 6'h0};
    bus.fill_v    = fv;
    bus.fill_addr = {fl, 6'h0};
    @(posedge clk_i);
    #1;
    done       = bus.learn_done;
    bus.miss_v = 1'b0;
    bus.fill_v = 1'b0;
  endtask

  task automatic fill(input line_t fl);
    logic x;
    op('0, 1'b0, 1'b1, fl, x);
  endtask

  task automatic miss_seq(input line_t p [8], input int rounds, output int n);
    logic dn;
    n = 0;
    for (int i = 0; i < rounds * nc; i++) begin
      op(p[i % nc], 1'b1, 1'b0, '0, dn);
      if (dn) begin
        n = i + 1;
        break;
      end
    end
  endtask

  task automatic settle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_n_i = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    bus.miss_v = 1'b0;
    bus.miss_addr = '0;
    bus.fill_v = 1'b0;
    bus.fill_addr = '0;
    #12;
    chk("rst_offset", 32'(bus.offset), 1);
    chk("rst_v", 32'(bus.offset_v), 1);
    chk("rst_done", 32'(bus.learn_done), 0);
    chk("rst_ready", 32'(bus.miss_ready_and), 1);
    @(negedge clk_i);
    reset_n_i = 1'b1;
`ifdef BP_ME_BOP_NEGATIVE_OFFSETS_EN
    fill(34'h100);
    pat = '{34'h500, 34'hFE, 34'h500, 34'h500, 34'h500, 34'h500, 34'h500, 34'h500};
    miss_seq(pat, 3, at);
    chk("t6_done_at", at, 18);
    settle();
    chk("t6_offset", 32'(bus.offset), 32'hF);
    chk("t6_v", 32'(bus.offset_v), 1);
`else
    fill(34'h100);
    pat = '{34'h200, 34'h200, 34'h102, 34'h200, 0, 0, 0, 0};
    miss_seq(pat, 3, at);
    chk("t1_done_at", at, 11);
    chk("t1_end_ready", 32'(bus.miss_ready_and), 0);
    chk("t1_offset_hold", 32'(bus.offset), 1);
    settle();
    chk("t1_offset", 32'(bus.offset), 3);
    chk("t1_v", 32'(bus.offset_v), 1);
    chk("t1_pulse", 32'(bus.learn_done), 0);
    chk("t1_ready", 32'(bus.miss_ready_and), 1);

    do_reset();
    pat = '{34'h500, 34'h500, 34'h500, 34'h500, 0, 0, 0, 0};
    miss_seq(pat, 4, at);
    chk("t2_done_at", at, 16);
    settle();
    chk("t2_v", 32'(bus.offset_v), 0);
    chk("t2_offset", 32'(bus.offset), 1);
    fill(34'h600);
    pat = '{34'h601, 34'h500, 34'h500, 34'h500, 0, 0, 0, 0};
    miss_seq(pat, 3, at);
    chk("t2_fill_done_at", at, 9);
    settle();
    chk("t2_fill_v", 32'(bus.offset_v), 1);
    chk("t2_fill_offset", 32'(bus.offset), 1);

    do_reset();
    fill(34'h301);
    pat = '{34'h500, 34'h302, 34'h500, 34'h304, 0, 0, 0, 0};
    miss_seq(pat, 2, at);
    chk("t3_early_done", at, 0);
    pat = '{34'h500, 34'h500, 34'h500, 34'h500, 0, 0, 0, 0};
    miss_seq(pat, 2, at);
    chk("t3_done_at", at, 8);
    settle();
    chk("t3_offset", 32'(bus.offset), 2);
    chk("t3_v", 32'(bus.offset_v), 1);

    op(34'h500, 1'b1, 1'b0, '0, d);
    op(34'h302, 1'b1, 1'b0, '0, d);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("t4_offset", 32'(bus.offset), 1);
    chk("t4_v", 32'(bus.offset_v), 1);
    chk("t4_done", 32'(bus.learn_done), 0);
    chk("t4_ready", 32'(bus.miss_ready_and), 1);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    pat = '{34'h500, 34'h302, 34'h500, 34'h304, 0, 0, 0, 0};
    miss_seq(pat, 4, at);
    chk("t4_done_at", at, 16);
    settle();
    chk("t4_v_after", 32'(bus.offset_v), 0);

    do_reset();
    op(34'h101, 1'b1, 1'b1, 34'h101, d);
    for (int i = 0; i < 3; i++) op(34'h500, 1'b1, 1'b0, '0, d);
    pat = '{34'h101, 34'h500, 34'h500, 34'h500, 0, 0, 0, 0};
    miss_seq(pat, 3, at);
    chk("t5_done_at", at, 9);
    settle();
    chk("t5_v", 32'(bus.offset_v), 1);
    chk("t5_offset", 32'(bus.offset), 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
